// File: rtl/mult_share_arb_pkg.sv
// mult_pkg: shared constants, tag type and id-width helper for the multiplier arbiter
package mult_pkg;
    localparam int MULT_LAT = 4;
    localparam int TAG_IDW = 3;
    typedef struct packed {
        logic                valid;
        logic [TAG_IDW-1:0]  id;
    } tag_t;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: request/response bundle between clients and the shared multiplier
interface mult_share_arb_if #(
    parameter int NUM_REQ  = 4,
    parameter int LENGTH   = 8,
    parameter int MULT_LAT = mult_pkg::MULT_LAT
);
    logic                           arb_en;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*LENGTH-1:0]      req_a;
    logic [NUM_REQ*LENGTH-1:0]      req_b;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [2*LENGTH-1:0]            rsp_data;
    logic                           busy;
    logic [$clog2(MULT_LAT+1)-1:0]  inflight;
    modport master (
        output arb_en, req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, busy, inflight
    );
    modport slave (
        input  arb_en, req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, busy, inflight
    );
endinterface

// File: rtl/mult_share_arb_rr_arbiter.sv
// rr_arbiter: round-robin grant search starting one past the last accepted requester
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_id
);
    logic [IW-1:0] last_grant;
    logic          found;
    // first valid requester after last_grant, wrapping; grant only when enabled and out of reset
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && valid[(int'(last_grant) + i) % NUM_REQ]) begin
                found    = 1'b1;
                grant_id = IW'((int'(last_grant) + i) % NUM_REQ);
            end
        end
        grant = (en && rst_n && found) ? NUM_REQ'(1) << grant_id : '0;
    end
    // pointer moves only on an actual transfer; reset parks it so requester 0 wins first
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= IW'(NUM_REQ - 1);
        else if (accept)
            last_grant <= grant_id;
    end
endmodule

// File: rtl/product.sv
// product: pipelined unsigned multiplier, operands captured on one edge, result four edges later
module product #(
    parameter int length = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [length-1:0]   a,
    input  logic [length-1:0]   b,
    output logic [2*length-1:0] op
);
    logic [length-1:0]   a_r;
    logic [length-1:0]   b_r;
    logic [2*length-1:0] p1;
    logic [2*length-1:0] p2;
    // operand capture, multiply, then two retiming stages to the output
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            p1  <= '0;
            p2  <= '0;
            op  <= '0;
        end else begin
            a_r <= a;
            b_r <= b;
            p1  <= {{length{1'b0}}, a_r} * {{length{1'b0}}, b_r};
            p2  <= p1;
            op  <= p2;
        end
    end
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one pipelined multiplier among requesters and routes results by tag
module mult_share_arb
    import mult_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int LENGTH   = 8,
    parameter int MULT_LAT = mult_pkg::MULT_LAT
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_share_arb_if.slave bus
);
    localparam int IW = id_w(NUM_REQ);
    localparam int CW = $clog2(MULT_LAT + 1);

    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       gid;
    logic                xfer;
    logic [LENGTH-1:0]   a;
    logic [LENGTH-1:0]   b;
    logic [2*LENGTH-1:0] op;
    tag_t                tags [MULT_LAT];
    tag_t                tail;
    logic [CW-1:0]       cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.arb_en),
        .valid    (bus.req_valid),
        .accept   (xfer),
        .grant    (grant),
        .grant_id (gid)
    );

    assign xfer          = |(bus.req_valid & grant);
    assign bus.req_ready = grant;
    assign a             = xfer ? bus.req_a[int'(gid)*LENGTH +: LENGTH] : '0;
    assign b             = xfer ? bus.req_b[int'(gid)*LENGTH +: LENGTH] : '0;

    product #(.length(LENGTH)) u_mul (
        .clk (clk),
        .rst (~rst_n),
        .a   (a),
        .b   (b),
        .op  (op)
    );

    assign tail          = tags[MULT_LAT-1];
    assign bus.rsp_valid = tail.valid ? NUM_REQ'(1) << tail.id : '0;
    assign bus.rsp_data  = tail.valid ? op : '0;
    assign bus.inflight  = cnt;
    assign bus.busy      = cnt != '0;

    // owner tags travel alongside the multiplier pipeline; counter tracks live stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MULT_LAT; i++) tags[i] <= '0;
            cnt <= '0;
        end else begin
            tags[0] <= '{valid: xfer, id: TAG_IDW'(gid)};
            for (int i = 1; i < MULT_LAT; i++) tags[i] <= tags[i-1];
            cnt <= cnt + CW'(xfer) - CW'(tail.valid);
        end
    end
endmodule
